// File: rtl/wisc_if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID decoupling queue.
//   fetch side : inst_in, pc_plus2_in, err_in, fetch_valid (into queue), full (out of queue)
//   decode side: inst_out, pc_plus2_out, err_out, valid_out (out), id_stall (in)
//   control    : flush (in), count (debug occupancy, out)
// modport slave is the queue itself; modport master is whoever drives it.
interface wisc_if_id_queue_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] inst_in;
    logic [WIDTH-1:0] pc_plus2_in;
    logic             err_in;
    logic             fetch_valid;
    logic             flush;
    logic             id_stall;
    logic [WIDTH-1:0] inst_out;
    logic [WIDTH-1:0] pc_plus2_out;
    logic             err_out;
    logic             valid_out;
    logic             full;
    logic [3:0]       count;

    modport master (
        output inst_in, pc_plus2_in, err_in, fetch_valid, flush, id_stall,
        input  inst_out, pc_plus2_out, err_out, valid_out, full, count
    );

    modport slave (
        input  inst_in, pc_plus2_in, err_in, fetch_valid, flush, id_stall,
        output inst_out, pc_plus2_out, err_out, valid_out, full, count
    );
endinterface

// File: rtl/wisc_if_id_queue.sv
// IF/ID decoupling queue: circular buffer of fetched {err, pc_plus2, inst}
// entries, presenting the oldest to decode (NOP 16'h0800 when empty).
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset; drops all entries immediately
//   q    - wisc_if_id_queue_if.slave: fetch push side, decode head side,
//          flush, full back-pressure and count occupancy.
// All status/head outputs decode from count and rd_ptr only, so there is no
// combinational path from any input to any output.
module wisc_if_id_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    wisc_if_id_queue_if.slave     q
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] pc_plus2;
        logic [WIDTH-1:0] inst;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_r;
    logic               valid;
    logic               is_full;
    logic               push;
    logic               pop;
    entry_t             head;

    // Explicit wrap compare so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Status and handshakes.
    always_comb begin
        valid   = (count_r != '0);
        is_full = (count_r == CNT_W'(DEPTH));
        push    = q.fetch_valid & ~is_full & ~q.flush;
        pop     = valid & ~q.id_stall & ~q.flush;
        head    = mem[rd_ptr];
    end

    // Head presentation; NOP/zeros when empty.
    assign q.valid_out    = valid;
    assign q.full         = is_full;
    assign q.count        = count_r;
    assign q.inst_out     = valid ? head.inst     : WIDTH'(16'h0800);
    assign q.pc_plus2_out = valid ? head.pc_plus2 : '0;
    assign q.err_out      = valid ? head.err      : 1'b0;

    // Pointer and occupancy state; flush realigns rd_ptr onto wr_ptr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            rd_ptr  <= wr_ptr;
            count_r <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{err: q.err_in, pc_plus2: q.pc_plus2_in, inst: q.inst_in};
        end
    end
endmodule

// File: tb/tb_wisc_if_id_queue.sv
module tb_wisc_if_id_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    wisc_if_id_queue_if #(.WIDTH(16)) a ();
    wisc_if_id_queue_if #(.WIDTH(16)) b ();

    wisc_if_id_queue #(.DEPTH(2), .WIDTH(16)) dut2 (.clk(clk), .rst(rst), .q(a));
    wisc_if_id_queue #(.DEPTH(3), .WIDTH(16)) dut3 (.clk(clk), .rst(rst), .q(b));

    // Wrap sequence for DEPTH=3: inputs and hand-computed head/count after each edge.
    logic        w_fv   [12] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 1, 0};
    logic        w_st   [12] = '{1, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [15:0] w_inst [12] = '{16'hC001, 16'hC002, 16'hC003, 16'hC004, 16'hC005, 16'hC005,
                                 16'h0000, 16'hC006, 16'hC007, 16'h0000, 16'hC008, 16'h0000};
    logic [15:0] w_head [12] = '{16'hC001, 16'hC001, 16'hC002, 16'hC002, 16'hC003, 16'hC004,
                                 16'hC005, 16'hC006, 16'hC006, 16'hC007, 16'hC008, 16'h0800};
    logic [3:0]  w_cnt  [12] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd2, 4'd2,
                                 4'd1, 4'd1, 4'd2, 4'd1, 4'd1, 4'd0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic fv, input logic [15:0] inst, input logic [15:0] pc,
                           input logic err, input logic stall, input logic fl);
        a.fetch_valid = fv;
        a.inst_in     = inst;
        a.pc_plus2_in = pc;
        a.err_in      = err;
        a.id_stall    = stall;
        a.flush       = fl;
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        b.fetch_valid = 1'b0; b.inst_in = '0; b.pc_plus2_in = '0;
        b.err_in = 1'b0; b.id_stall = 1'b0; b.flush = 1'b0;

        // Reset and idle.
        step();
        check("rst_count",    32'(a.count), 32'd0);
        check("rst_inst",     32'(a.inst_out), 32'h0800);
        check("rst_valid",    32'(a.valid_out), 32'd0);
        check("rst_full",     32'(a.full), 32'd0);
        check("rst_pc",       32'(a.pc_plus2_out), 32'd0);
        rst = 1'b0;
        step();
        check("idle_inst",    32'(a.inst_out), 32'h0800);
        check("idle_count",   32'(a.count), 32'd0);

        // Streaming, one cycle latency, count steady at 1.
        drive_a(1'b1, 16'hA001, 16'h0002, 1'b0, 1'b0, 1'b0);
        step();
        check("stream1_inst", 32'(a.inst_out), 32'hA001);
        check("stream1_pc",   32'(a.pc_plus2_out), 32'h0002);
        check("stream1_cnt",  32'(a.count), 32'd1);
        drive_a(1'b1, 16'hA002, 16'h0004, 1'b0, 1'b0, 1'b0);
        step();
        check("stream2_inst", 32'(a.inst_out), 32'hA002);
        check("stream2_pc",   32'(a.pc_plus2_out), 32'h0004);
        check("stream2_cnt",  32'(a.count), 32'd1);
        drive_a(1'b1, 16'hA003, 16'h0006, 1'b0, 1'b0, 1'b0);
        step();
        check("stream3_inst", 32'(a.inst_out), 32'hA003);
        check("stream3_pc",   32'(a.pc_plus2_out), 32'h0006);
        check("stream3_cnt",  32'(a.count), 32'd1);
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("drain_valid",  32'(a.valid_out), 32'd0);
        check("drain_inst",   32'(a.inst_out), 32'h0800);

        // Fill and back-pressure.
        drive_a(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b1, 1'b0);
        step();
        check("fill1_cnt",    32'(a.count), 32'd1);
        drive_a(1'b1, 16'h2222, 16'h0012, 1'b0, 1'b1, 1'b0);
        step();
        check("fill2_cnt",    32'(a.count), 32'd2);
        check("fill2_full",   32'(a.full), 32'd1);
        drive_a(1'b1, 16'h3333, 16'h0014, 1'b0, 1'b1, 1'b0);
        step();
        check("blocked_cnt",  32'(a.count), 32'd2);
        check("blocked_head", 32'(a.inst_out), 32'h1111);
        drive_a(1'b1, 16'h3333, 16'h0014, 1'b0, 1'b0, 1'b0);
        step();
        check("rel1_head",    32'(a.inst_out), 32'h2222);
        check("rel1_cnt",     32'(a.count), 32'd1);
        check("rel1_full",    32'(a.full), 32'd0);
        step();
        check("rel2_head",    32'(a.inst_out), 32'h3333);
        check("rel2_pc",      32'(a.pc_plus2_out), 32'h0014);
        check("rel2_cnt",     32'(a.count), 32'd1);
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("rel3_cnt",     32'(a.count), 32'd0);

        // Flush discards queued entries and the same-cycle fetch.
        drive_a(1'b1, 16'h4444, 16'h0020, 1'b0, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 16'h5555, 16'h0022, 1'b0, 1'b1, 1'b0);
        step();
        check("preflush_cnt", 32'(a.count), 32'd2);
        drive_a(1'b1, 16'h6666, 16'h0024, 1'b0, 1'b1, 1'b1);
        step();
        check("flush_cnt",    32'(a.count), 32'd0);
        check("flush_inst",   32'(a.inst_out), 32'h0800);
        check("flush_valid",  32'(a.valid_out), 32'd0);
        drive_a(1'b1, 16'h7777, 16'h0040, 1'b0, 1'b1, 1'b0);
        step();
        check("post_head",    32'(a.inst_out), 32'h7777);
        check("post_cnt",     32'(a.count), 32'd1);
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("post_drain",   32'(a.count), 32'd0);

        // Empty with id_stall: NOP stays.
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        step();
        check("empty_stall",  32'(a.inst_out), 32'h0800);
        check("empty_cnt",    32'(a.count), 32'd0);

        // Error flag travels with its instruction.
        drive_a(1'b1, 16'hBEEF, 16'h0050, 1'b1, 1'b1, 1'b0);
        step();
        check("err1_head",    32'(a.inst_out), 32'hBEEF);
        check("err1_flag",    32'(a.err_out), 32'd1);
        drive_a(1'b1, 16'hCAFE, 16'h0052, 1'b0, 1'b1, 1'b0);
        step();
        check("err2_flag",    32'(a.err_out), 32'd1);
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        step();
        check("err3_head",    32'(a.inst_out), 32'hCAFE);
        check("err3_flag",    32'(a.err_out), 32'd0);
        step();
        check("err4_flag",    32'(a.err_out), 32'd0);

        // Asynchronous reset mid-cycle with two entries queued.
        drive_a(1'b1, 16'h8888, 16'h0060, 1'b0, 1'b1, 1'b0);
        step();
        drive_a(1'b1, 16'h9999, 16'h0062, 1'b0, 1'b1, 1'b0);
        step();
        check("arst_pre",     32'(a.count), 32'd2);
        drive_a(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_cnt",     32'(a.count), 32'd0);
        check("arst_valid",   32'(a.valid_out), 32'd0);
        check("arst_inst",    32'(a.inst_out), 32'h0800);
        #1;
        rst = 1'b0;
        step();
        check("arst_after",   32'(a.count), 32'd0);

        // Pointer wrap on the DEPTH=3 instance.
        for (int i = 0; i < 12; i++) begin
            b.fetch_valid = w_fv[i];
            b.inst_in     = w_inst[i];
            b.pc_plus2_in = w_inst[i] ^ 16'hFFFF;
            b.id_stall    = w_st[i];
            step();
            check($sformatf("wrap%0d_head", i), 32'(b.inst_out), 32'(w_head[i]));
            check($sformatf("wrap%0d_cnt", i),  32'(b.count), 32'(w_cnt[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
